// File: rtl/host_mem_wr_arbiter_if.sv
// Avalon-style burst write channel bundle, N lanes wide; used for both the
// per-source request side (N = NUM_SRC) and the shared host channel (N = 1).
interface host_mem_wr_arbiter_if #(
    parameter int N           = 1,
    parameter int ADDR_WIDTH  = 42,
    parameter int DATA_WIDTH  = 512,
    parameter int BURST_WIDTH = 7
);
    // Handshake: a beat transfers on a lane when write=1 and waitrequest=0 in
    // the same cycle; the master holds the beat stable while waitrequest=1.
    // writeresponsevalid is a one-cycle pulse per completed burst, in issue order.
    logic [N-1:0]                write;
    logic [N*ADDR_WIDTH-1:0]     address;
    logic [N*DATA_WIDTH-1:0]     writedata;
    logic [N*BURST_WIDTH-1:0]    burstcount;
    logic [N*DATA_WIDTH/8-1:0]   byteenable;
    logic [N-1:0]                waitrequest;
    logic [N-1:0]                writeresponsevalid;

    modport master (
        output write, address, writedata, burstcount, byteenable,
        input  waitrequest, writeresponsevalid
    );

    modport slave (
        input  write, address, writedata, burstcount, byteenable,
        output waitrequest, writeresponsevalid
    );
endinterface

// File: rtl/host_mem_wr_arbiter.sv
// Round-robin burst-atomic arbiter for the host_mem write channel; tracks the
// owner of each accepted burst and steers write responses back in order.
module host_mem_wr_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int ADDR_WIDTH  = 42,
    parameter int DATA_WIDTH  = 512,
    parameter int BURST_WIDTH = 7,
    parameter int RESP_DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    host_mem_wr_arbiter_if.slave   src,
    host_mem_wr_arbiter_if.master  wr,
    output logic                   err_resp_underflow
);
    localparam int SEL_W = $clog2(NUM_SRC);
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int BE_W  = DATA_WIDTH / 8;

    logic                   locked;
    logic [SEL_W-1:0]       owner;
    logic [BURST_WIDTH-1:0] beats_left;
    logic [SEL_W-1:0]       rr_ptr;
    logic [SEL_W-1:0]       ids [RESP_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W:0]         count;
    logic [NUM_SRC-1:0]     resp_q;

    logic [SEL_W-1:0]       grant;
    logic                   found;
    logic [SEL_W:0]         cand;
    logic [SEL_W-1:0]       sel;
    logic                   sel_active;
    logic                   fifo_full;
    logic                   accept;
    logic                   first_beat;
    logic                   pop;
    logic [BURST_WIDTH-1:0] cur_bc;
    logic [BURST_WIDTH-1:0] bc_eff;

    // Rotating priority search starting at rr_ptr; defaults to rr_ptr when idle.
    always_comb begin
        grant = rr_ptr;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = {1'b0, rr_ptr} + (SEL_W+1)'(i);
            if (cand >= (SEL_W+1)'(NUM_SRC)) cand = cand - (SEL_W+1)'(NUM_SRC);
            if (!found && src.write[cand[SEL_W-1:0]]) begin
                found = 1'b1;
                grant = cand[SEL_W-1:0];
            end
        end
    end

    assign fifo_full  = (count == (PTR_W+1)'(RESP_DEPTH));
    assign sel        = locked ? owner : grant;
    // A locked burst always proceeds; new bursts need a free response slot.
    assign sel_active = locked || !fifo_full;

    always_comb begin
        wr.write       = sel_active && src.write[sel];
        wr.address     = src.address[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
        wr.writedata   = src.writedata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        wr.burstcount  = src.burstcount[int'(sel)*BURST_WIDTH +: BURST_WIDTH];
        wr.byteenable  = src.byteenable[int'(sel)*BE_W +: BE_W];
        src.waitrequest = '1;
        if (sel_active) src.waitrequest[sel] = wr.waitrequest[0];
    end

    assign cur_bc     = src.burstcount[int'(sel)*BURST_WIDTH +: BURST_WIDTH];
    assign bc_eff     = (cur_bc == '0) ? BURST_WIDTH'(1) : cur_bc;
    assign accept     = wr.write[0] && !wr.waitrequest[0];
    assign first_beat = accept && !locked;
    assign pop        = wr.writeresponsevalid[0] && (count != '0);

    assign src.writeresponsevalid = resp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            locked             <= 1'b0;
            owner              <= '0;
            beats_left         <= '0;
            rr_ptr             <= '0;
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            count              <= '0;
            resp_q             <= '0;
            err_resp_underflow <= 1'b0;
        end else begin
            if (first_beat) begin
                rr_ptr <= (sel == SEL_W'(NUM_SRC-1)) ? '0 : sel + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
                if (bc_eff > BURST_WIDTH'(1)) begin
                    locked     <= 1'b1;
                    owner      <= sel;
                    beats_left <= bc_eff - 1'b1;
                end
            end else if (accept) begin
                beats_left <= beats_left - 1'b1;
                if (beats_left == BURST_WIDTH'(1)) locked <= 1'b0;
            end

            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({first_beat, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            resp_q <= '0;
            if (pop) resp_q[ids[rd_ptr]] <= 1'b1;
            if (wr.writeresponsevalid[0] && (count == '0)) err_resp_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (first_beat) ids[wr_ptr] <= sel;
    end
endmodule

// File: tb/tb_host_mem_wr_arbiter.sv
// Directed bench for host_mem_wr_arbiter: grant order, burst locking, response
// steering, FIFO-full back-pressure, underflow flag and mid-burst reset.
module tb_host_mem_wr_arbiter;
  localparam int NS = 4;
  localparam int AW = 42;
  localparam int DW = 512;
  localparam int BW = 7;
  localparam int RD = 16;

  logic clk;
  logic reset;
  logic err;

  int n_checks;
  int n_pass;

  host_mem_wr_arbiter_if #(.N(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) src_if ();
  host_mem_wr_arbiter_if #(.N(1),  .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) wr_if ();

  host_mem_wr_arbiter #(
    .NUM_SRC(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .RESP_DEPTH(RD)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .src                (src_if.slave),
    .wr                 (wr_if.master),
    .err_resp_underflow (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // scoreboard check
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic w, input logic [BW-1:0] bc);
    src_if.write[i] = w;
    src_if.burstcount[i*BW +: BW] = bc;
  endtask

  task automatic clear_src();
    src_if.write = '0;
  endtask

  logic [3:0] m;
  logic [5:0] wpat;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    src_if.write = '0;
    src_if.address = '0;
    src_if.writedata = '0;
    src_if.burstcount = '0;
    src_if.byteenable = '1;
    wr_if.waitrequest = 1'b0;
    wr_if.writeresponsevalid = 1'b0;
    for (int i = 0; i < NS; i++) begin
      src_if.address[i*AW +: AW] = AW'(32'h1000 + i);
      src_if.writedata[i*DW +: 32] = 32'(i + 1);
    end
    tick();
    tick();

    // reset state
    chk("rst_wr_write", 64'(wr_if.write), 64'(0));
    chk("rst_src_wait", 64'(src_if.waitrequest), 64'(4'b1110));
    chk("rst_resp", 64'(src_if.writeresponsevalid), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    reset = 1'b0;
    tick();

    // all sources single-beat, continuous: order 0,1,2,3,0,1,2,3
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 7'd1);
    for (int k = 0; k < 8; k++) begin
      #1;
      m = ~(4'b0001 << (k % 4));
      chk("t1_wr_write", 64'(wr_if.write), 64'(1));
      chk("t1_addr", 64'(wr_if.address), 64'(32'h1000 + k % 4));
      chk("t1_data", 64'(wr_if.writedata[31:0]), 64'(k % 4 + 1));
      chk("t1_src_wait", 64'(src_if.waitrequest), 64'(m));
      tick();
    end
    clear_src();
    wr_if.writeresponsevalid = 1'b1;
    #1;
    chk("t1_resp_latency", 64'(src_if.writeresponsevalid), 64'(0));
    for (int r = 0; r < 8; r++) begin
      tick();
      m = 4'b0001 << (r % 4);
      chk("t1_resp", 64'(src_if.writeresponsevalid), 64'(m));
    end
    wr_if.writeresponsevalid = 1'b0;
    tick();
    chk("t1_resp_idle", 64'(src_if.writeresponsevalid), 64'(0));
    chk("t1_err", 64'(err), 64'(0));

    // source 1 burst of 4 with a 2-cycle stall, source 2 waiting
    set_src(1, 1'b1, 7'd4);
    set_src(2, 1'b1, 7'd1);
    wpat = 6'b001100;
    for (int c = 0; c < 6; c++) begin
      wr_if.waitrequest = wpat[c];
      #1;
      m = wpat[c] ? 4'b1111 : 4'b1101;
      chk("t2_addr", 64'(wr_if.address), 64'(32'h1001));
      chk("t2_src_wait", 64'(src_if.waitrequest), 64'(m));
      if (c == 0) chk("t2_bc", 64'(wr_if.burstcount), 64'(4));
      tick();
    end
    wr_if.waitrequest = 1'b0;
    #1;
    chk("t2_next_addr", 64'(wr_if.address), 64'(32'h1002));
    chk("t2_next_wait", 64'(src_if.waitrequest), 64'(4'b1011));
    tick();
    clear_src();
    wr_if.writeresponsevalid = 1'b1;
    tick();
    chk("t2_resp_a", 64'(src_if.writeresponsevalid), 64'(4'b0010));
    tick();
    chk("t2_resp_b", 64'(src_if.writeresponsevalid), 64'(4'b0100));
    wr_if.writeresponsevalid = 1'b0;
    tick();

    // FIFO full: 16 accepted, 17th stalls until a response pops a slot
    set_src(0, 1'b1, 7'd1);
    for (int k = 0; k < RD; k++) begin
      #1;
      chk("t3_accept", 64'(wr_if.write), 64'(1));
      tick();
    end
    #1;
    chk("t3_full_write", 64'(wr_if.write), 64'(0));
    chk("t3_full_wait", 64'(src_if.waitrequest), 64'(4'b1111));
    wr_if.writeresponsevalid = 1'b1;
    #1;
    chk("t3_full_same_cycle", 64'(wr_if.write), 64'(0));
    tick();
    wr_if.writeresponsevalid = 1'b0;
    #1;
    chk("t3_after_pop_write", 64'(wr_if.write), 64'(1));
    chk("t3_after_pop_resp", 64'(src_if.writeresponsevalid), 64'(4'b0001));
    tick();
    clear_src();
    wr_if.writeresponsevalid = 1'b1;
    for (int r = 0; r < RD; r++) begin
      tick();
      chk("t3_drain", 64'(src_if.writeresponsevalid), 64'(4'b0001));
    end
    wr_if.writeresponsevalid = 1'b0;
    tick();
    chk("t3_drain_err", 64'(err), 64'(0));

    // issue order 3,0,3 (source 3 burstcount 0 behaves as 1)
    set_src(0, 1'b1, 7'd1);
    set_src(3, 1'b1, 7'd0);
    #1;
    chk("t4_g0", 64'(wr_if.address), 64'(32'h1003));
    tick();
    chk("t4_g1", 64'(wr_if.address), 64'(32'h1000));
    tick();
    chk("t4_g2", 64'(wr_if.address), 64'(32'h1003));
    tick();
    clear_src();
    wr_if.writeresponsevalid = 1'b1;
    #1;
    chk("t4_resp_latency", 64'(src_if.writeresponsevalid), 64'(0));
    tick();
    chk("t4_resp_a", 64'(src_if.writeresponsevalid), 64'(4'b1000));
    tick();
    chk("t4_resp_b", 64'(src_if.writeresponsevalid), 64'(4'b0001));
    tick();
    chk("t4_resp_c", 64'(src_if.writeresponsevalid), 64'(4'b1000));
    wr_if.writeresponsevalid = 1'b0;
    tick();
    chk("t4_resp_idle", 64'(src_if.writeresponsevalid), 64'(0));
    chk("t4_err", 64'(err), 64'(0));

    // response with nothing outstanding
    wr_if.writeresponsevalid = 1'b1;
    tick();
    wr_if.writeresponsevalid = 1'b0;
    #1;
    chk("t5_no_pulse", 64'(src_if.writeresponsevalid), 64'(0));
    chk("t5_err_set", 64'(err), 64'(1));
    tick();
    tick();
    chk("t5_err_sticky", 64'(err), 64'(1));

    // reset at beat 2 of an 8-beat burst
    set_src(1, 1'b1, 7'd1);
    #1;
    chk("t6_pre_addr", 64'(wr_if.address), 64'(32'h1001));
    tick();
    clear_src();
    set_src(2, 1'b1, 7'd8);
    #1;
    chk("t6_burst_addr", 64'(wr_if.address), 64'(32'h1002));
    tick();
    set_src(0, 1'b1, 7'd1);
    set_src(3, 1'b1, 7'd1);
    reset = 1'b1;
    #1;
    chk("t6_locked_addr", 64'(wr_if.address), 64'(32'h1002));
    chk("t6_locked_wait", 64'(src_if.waitrequest), 64'(4'b1011));
    tick();
    reset = 1'b0;
    #1;
    chk("t6_post_addr", 64'(wr_if.address), 64'(32'h1000));
    chk("t6_post_wait", 64'(src_if.waitrequest), 64'(4'b1110));
    chk("t6_post_err", 64'(err), 64'(0));
    clear_src();
    wr_if.writeresponsevalid = 1'b1;
    tick();
    wr_if.writeresponsevalid = 1'b0;
    #1;
    chk("t6_fifo_empty_pulse", 64'(src_if.writeresponsevalid), 64'(0));
    chk("t6_fifo_empty_err", 64'(err), 64'(1));
    tick();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
